// File: rtl/majority_vote_pipe.sv
// Pipelined N-input threshold voter with valid/ready handshake and optional sliding-window majority.
// Define MAJ_DISAGREE_EN to add the disagree flag and saturating disagree counter outputs.
module majority_vote_pipe #(
    parameter int N   = 5,
    parameter int WIN = 8,
    localparam int CW = $clog2(N + 1),
    localparam int WW = $clog2(WIN + 1),
    localparam int OW = (CW > WW) ? CW : WW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  x,
    input  logic [CW-1:0] thr,
    input  logic          mode,
    input  logic          clr,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef MAJ_DISAGREE_EN
    output logic          disagree,
    output logic [15:0]   disagree_cnt,
`endif
    output logic          z,
    output logic [OW-1:0] cnt
);

    localparam logic [CW-1:0] DEF_THR = CW'(N / 2 + 1);

    logic          run;
    logic          s1_valid;
    logic [CW-1:0] s1_pc;
    logic [CW-1:0] s1_thr;
    logic          s1_mode;
    logic [WIN-1:0] h;
    logic [WW-1:0] wc;

    logic [CW-1:0] pc_x;
    logic [CW-1:0] thr_eff;
    logic          accept;
    logic          xfer;
    logic          v;
    logic [WW-1:0] wc_next;
    logic [WW:0]   wc_x2;
    logic          win_maj;

    // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        pc_x = '0;
        for (int i = 0; i < N; i++) begin
            pc_x = pc_x + CW'(x[i]);
        end
    end

    assign thr_eff  = (thr == '0) ? DEF_THR : thr;
    assign xfer     = s1_valid && (!out_valid || out_ready);
    assign in_ready = run && !clr && (!s1_valid || !out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign v       = (s1_pc >= s1_thr);
    // The window count tracks incrementally: the new vote enters, the oldest bit leaves.
    assign wc_next = wc + WW'(v) - WW'(h[WIN-1]);
    assign wc_x2   = {wc_next, 1'b0};
    assign win_maj = (wc_x2 > (WW + 1)'(WIN));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pc    <= '0;
            s1_thr   <= '0;
            s1_mode  <= 1'b0;
        end else if (clr) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_pc    <= pc_x;
            s1_thr   <= thr_eff;
            s1_mode  <= mode;
        end else if (xfer) begin
            s1_valid <= 1'b0;
        end
    end

    // NOTE: the vote history is reset like any control register because its contents decide the next results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            z         <= 1'b0;
            cnt       <= '0;
            h         <= '0;
            wc        <= '0;
        end else if (clr) begin
            out_valid <= 1'b0;
            h         <= '0;
            wc        <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            h         <= {h[WIN-2:0], v};
            wc        <= wc_next;
            z         <= s1_mode ? win_maj : v;
            cnt       <= s1_mode ? OW'(wc_next) : OW'(s1_pc);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MAJ_DISAGREE_EN
    logic split;

    assign split = (s1_pc != '0) && (s1_pc != CW'(N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disagree     <= 1'b0;
            disagree_cnt <= '0;
        end else if (clr) begin
            disagree_cnt <= '0;
        end else if (xfer) begin
            disagree <= split;
            if (split && (disagree_cnt != 16'hFFFF)) begin
                disagree_cnt <= disagree_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_majority_vote_pipe.sv
// Scoreboard bench for majority_vote_pipe (N=5, WIN=8); a monitor predicts each accepted sample.
module tb_majority_vote_pipe;

    localparam int N   = 5;
    localparam int WIN = 8;
    localparam int CW  = 3;
    localparam int OW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  x = '0;
    logic [CW-1:0] thr = '0;
    logic          mode = 1'b0;
    logic          clr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          z;
    logic [OW-1:0] cnt;
`ifdef MAJ_DISAGREE_EN
    logic          disagree;
    logic [15:0]   disagree_cnt;
`endif

    majority_vote_pipe #(.N(N), .WIN(WIN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .thr(thr), .mode(mode), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef MAJ_DISAGREE_EN
        .disagree(disagree), .disagree_cnt(disagree_cnt),
`endif
        .z(z), .cnt(cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          z;
        logic [OW-1:0] cnt;
        logic          dis;
    } exp_t;

    exp_t           sb[$];
    exp_t           e;
    logic [WIN-1:0] hist = '0;
    int             checks = 0;
    int             failures = 0;
    logic           hold = 1'b0;
    logic           hold_z;
    logic [OW-1:0]  hold_cnt;
    logic           last_z = 1'b0;
    logic [OW-1:0]  last_cnt = '0;
    int             out_count = 0;

    function automatic int popc(input logic [31:0] b);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(b[i]);
        return n;
    endfunction

    // Monitor: samples just before each rising edge, when all inputs and outputs are settled.
    always begin
        int pc, t, wcm;
        logic vm;
        @(negedge clk);
        #4;
        if (!rst_n || clr) begin
            sb.delete();
            hist = '0;
            hold = 1'b0;
        end else begin
            if (hold) begin
                checks++;
                if (!(out_valid === 1'b1 && z === hold_z && cnt === hold_cnt)) begin
                    failures++;
                    $display("FAIL hold_stable: got v=%b z=%b cnt=%0d, want v=1 z=%b cnt=%0d",
                             out_valid, z, cnt, hold_z, hold_cnt);
                end
            end
            hold     = out_valid && !out_ready;
            hold_z   = z;
            hold_cnt = cnt;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: got z=%b cnt=%0d, want no output", z, cnt);
                end else begin
                    e = sb.pop_front();
                    if (z !== e.z || cnt !== e.cnt) begin
                        failures++;
                        $display("FAIL result: got z=%b cnt=%0d, want z=%b cnt=%0d", z, cnt, e.z, e.cnt);
                    end
`ifdef MAJ_DISAGREE_EN
                    checks++;
                    if (disagree !== e.dis) begin
                        failures++;
                        $display("FAIL disagree: got %b, want %b", disagree, e.dis);
                    end
`endif
                end
                last_z   = z;
                last_cnt = cnt;
                out_count++;
            end
            if (in_valid && in_ready) begin
                pc   = popc(32'(x));
                t    = (thr == '0) ? (N / 2 + 1) : int'(thr);
                vm   = (pc >= t);
                hist = {hist[WIN-2:0], vm};
                wcm  = popc(32'(hist));
                e.z   = mode ? (2 * wcm > WIN) : vm;
                e.cnt = mode ? OW'(wcm) : OW'(pc);
                e.dis = (pc != 0) && (pc != N);
                sb.push_back(e);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; returns at the falling edge after the sample is taken.
    task automatic send(input logic [N-1:0] xv, input logic [CW-1:0] tv, input logic mv);
        bit ok = 1'b0;
        x = xv; thr = tv; mode = mv; in_valid = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            #4;
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, want accept");
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100 && (sb.size() != 0 || out_valid); c++) @(negedge clk);
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL clr_in_ready: got %b, want 0", in_ready);
        end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || z !== 1'b0 || cnt !== '0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got v=%b z=%b cnt=%0d rdy=%b, want all 0", out_valid, z, cnt, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b, want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_default_thr();
        out_ready = 1'b1;
        fork
            begin
                send(5'b00111, 3'd0, 1'b0);
                send(5'b00011, 3'd0, 1'b0);
            end
            begin
                #1;
                checks++;
                if (out_valid !== 1'b0 || z !== 1'b0) begin
                    failures++;
                    $display("FAIL pre_out: got v=%b z=%b, want v=0 z=0", out_valid, z);
                end
                @(negedge clk); #1;
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL latency_early: got out_valid=%b, want 0", out_valid);
                end
                @(negedge clk); #1;
                checks++;
                if (out_valid !== 1'b1 || z !== 1'b1 || cnt !== 4'd3) begin
                    failures++;
                    $display("FAIL default_thr_a: got v=%b z=%b cnt=%0d, want v=1 z=1 cnt=3", out_valid, z, cnt);
                end
                @(negedge clk); #1;
                checks++;
                if (out_valid !== 1'b1 || z !== 1'b0 || cnt !== 4'd2) begin
                    failures++;
                    $display("FAIL default_thr_b: got v=%b z=%b cnt=%0d, want v=1 z=0 cnt=2", out_valid, z, cnt);
                end
            end
        join
        @(negedge clk);
        wait_drain();
    endtask

    task automatic test_threshold();
        logic [N-1:0]  xs[3] = '{5'b00001, 5'b11110, 5'b11111};
        logic [CW-1:0] ts[3] = '{3'd1, 3'd5, 3'd7};
        logic          zs[3] = '{1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(xs[i], ts[i], 1'b0);
            wait_drain();
            checks++;
            if (last_z !== zs[i]) begin
                failures++;
                $display("FAIL threshold_%0d: got z=%b, want z=%b", i, last_z, zs[i]);
            end
        end
    endtask

    task automatic test_temporal();
        out_ready = 1'b1;
        do_clr();
        for (int i = 0; i < 5; i++) send(5'b11111, 3'd0, 1'b1);
        wait_drain();
        checks++;
        if (last_cnt !== 4'd5 || last_z !== 1'b1) begin
            failures++;
            $display("FAIL temporal_ones: got z=%b cnt=%0d, want z=1 cnt=5", last_z, last_cnt);
        end
        for (int i = 0; i < 4; i++) send(5'b00000, 3'd0, 1'b1);
        wait_drain();
        checks++;
        if (last_cnt !== 4'd4 || last_z !== 1'b0) begin
            failures++;
            $display("FAIL temporal_tie: got z=%b cnt=%0d, want z=0 cnt=4", last_z, last_cnt);
        end
    endtask

    task automatic test_back_to_back();
        time t0;
        out_ready = 1'b1;
        t0 = $time;
        for (int i = 0; i < 8; i++) send(N'($urandom_range(0, 31)), CW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        checks++;
        if (($time - t0) != 80) begin
            failures++;
            $display("FAIL throughput: got %0d cycles for 8 samples, want 8", ($time - t0) / 10);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int base;
        base = out_count;
        out_ready = 1'b0;
        fork
            begin
                send(5'b11111, 3'd0, 1'b1);
                send(5'b00000, 3'd0, 1'b1);
                send(5'b11111, 3'd0, 1'b1);
                send(5'b10101, 3'd0, 1'b1);
            end
            begin
                repeat (2) @(negedge clk);
                #4;
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_ready_a: got %b, want 0", in_ready);
                end
                @(negedge clk); #4;
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_ready_b: got %b, want 0", in_ready);
                end
                @(negedge clk);
                out_ready = 1'b1;
                #1;
                checks++;
                if (in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL release_ready: got %b, want 1", in_ready);
                end
            end
        join
        wait_drain();
        checks++;
        if (out_count - base != 4) begin
            failures++;
            $display("FAIL bp_count: got %0d outputs, want 4", out_count - base);
        end
    endtask

    task automatic test_clr();
        out_ready = 1'b0;
        send(5'b11111, 3'd0, 1'b1);
        send(5'b11111, 3'd0, 1'b1);
        do_clr();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clr_flush: got out_valid=%b, want 0", out_valid);
        end
        @(negedge clk);
        out_ready = 1'b1;
        send(5'b11111, 3'd0, 1'b1);
        wait_drain();
        checks++;
        if (last_cnt !== 4'd1) begin
            failures++;
            $display("FAIL clr_window: got cnt=%0d, want 1", last_cnt);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(5'b11111, 3'd0, 1'b0);
        send(5'b11111, 3'd0, 1'b0);
        #2;
        checks++;
        if (out_valid !== 1'b1 || z !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: got v=%b z=%b, want v=1 z=1", out_valid, z);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || z !== 1'b0 || cnt !== '0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got v=%b z=%b cnt=%0d rdy=%b, want all 0", out_valid, z, cnt, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        send(5'b11111, 3'd0, 1'b1);
        wait_drain();
        checks++;
        if (last_cnt !== 4'd1 || last_z !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: got z=%b cnt=%0d, want z=0 cnt=1", last_z, last_cnt);
        end
    endtask

`ifdef MAJ_DISAGREE_EN
    task automatic test_disagree();
        out_ready = 1'b1;
        do_clr();
        send(5'b00000, 3'd0, 1'b0);
        send(5'b10101, 3'd0, 1'b0);
        send(5'b11111, 3'd0, 1'b0);
        wait_drain();
        checks++;
        if (disagree_cnt !== 16'd1) begin
            failures++;
            $display("FAIL disagree_cnt: got %0d, want 1", disagree_cnt);
        end
        for (int i = 0; i < 70000; i++) send(5'b10101, 3'd0, 1'b0);
        wait_drain();
        checks++;
        if (disagree_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL disagree_sat: got %h, want ffff", disagree_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_default_thr();
        test_threshold();
        test_temporal();
        test_back_to_back();
        test_backpressure();
        test_clr();
        test_async_reset();
`ifdef MAJ_DISAGREE_EN
        test_disagree();
`endif
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL leftover: got %0d expected results unmatched, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
